// File: rtl/reset_sequencer.sv
// Power-up sequencer: enables the PLL, waits for stable lock, then releases reset domains in order.
// Define RESET_SEQ_LOCK_LOSS_RESTART_EN to restart automatically on lock loss instead of faulting.
module reset_sequencer #(
  parameter int NUM_DOMAINS  = 3,
  parameter int DWELL_CYCLES = 5,
  parameter int LOCK_STABLE  = 4,
  parameter int LOCK_TIMEOUT = 1000,
  parameter int ACK_TIMEOUT  = 256
) (
  input  logic                   clk,
  input  logic                   hard_reset,
  input  logic                   pll_lock,
  input  logic [NUM_DOMAINS-1:0] domain_ready,
  input  logic                   soft_restart,
  output logic                   pll_enable,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic [NUM_DOMAINS-1:0] domain_enable,
  output logic                   seq_done,
  output logic                   seq_error,
  output logic [1:0]             error_code,
  output logic [3:0]             fault_domain,
  output logic [3:0]             restart_count
);

  localparam int TMAX_A = (LOCK_TIMEOUT > ACK_TIMEOUT) ? LOCK_TIMEOUT : ACK_TIMEOUT;
  localparam int TMAX   = (TMAX_A > DWELL_CYCLES) ? TMAX_A : DWELL_CYCLES;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int SW     = $clog2(LOCK_STABLE + 1);

  // Thresholds are "last cycle" values: the timer reads 0 on the entry cycle.
  localparam logic [TW-1:0] LOCK_TO_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] ACK_TO_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] DWELL_LAST   = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX    = TW'(TMAX);
  localparam logic [SW-1:0] STAB_LAST    = SW'(LOCK_STABLE - 1);
  localparam logic [SW-1:0] STAB_MAX     = SW'(LOCK_STABLE);
  localparam logic [3:0]    IDX_LAST     = 4'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] DOM_ONE  = NUM_DOMAINS'(1);
  localparam logic [NUM_DOMAINS-1:0] DOM_ALL  = {NUM_DOMAINS{1'b1}};
  localparam logic [NUM_DOMAINS-1:0] DOM_NONE = {NUM_DOMAINS{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLL_ON    = 3'd1,
    S_RELEASE   = 3'd2,
    S_ENABLE    = 3'd3,
    S_RUN       = 3'd4,
    S_LOCK_LOST = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  state_t                   state_r, state_s;
  logic [TW-1:0]            timer_r;
  logic [SW-1:0]            stab_r;
  logic [3:0]               idx_r, idx_s;
  logic [1:0]               error_code_s;
  logic [3:0]               fault_domain_s;
  logic [3:0]               restart_count_s;
  logic                     pll_enable_s;
  logic [NUM_DOMAINS-1:0]   domain_reset_s;
  logic [NUM_DOMAINS-1:0]   domain_enable_s;
  logic [NUM_DOMAINS-1:0]   cur_mask_s;
  logic [NUM_DOMAINS-1:0]   next_mask_s;
  logic                     ready_s;

  assign cur_mask_s  = DOM_ONE << idx_r;
  assign next_mask_s = DOM_ONE << idx_s;
  assign ready_s     = |(domain_ready & cur_mask_s);

  // Next-state, domain index and fault bookkeeping.
  always_comb begin
    state_s        = state_r;
    idx_s          = idx_r;
    error_code_s   = error_code;
    fault_domain_s = fault_domain;
`ifdef RESET_SEQ_LOCK_LOSS_RESTART_EN
    restart_count_s = restart_count;
`else
    restart_count_s = 4'd0;
`endif
    case (state_r)
      S_IDLE: begin
        state_s = S_PLL_ON;
      end
      S_PLL_ON: begin
        // Lock has priority over a coincident timeout.
        if (pll_lock && (stab_r >= STAB_LAST)) begin
          state_s = S_RELEASE;
          idx_s   = 4'd0;
        end else if (timer_r >= LOCK_TO_LAST) begin
          state_s        = S_FAULT;
          error_code_s   = 2'd1;
          fault_domain_s = 4'd0;
        end else begin
          state_s = S_PLL_ON;
        end
      end
      S_RELEASE: begin
        if (timer_r >= DWELL_LAST) begin
          state_s = S_ENABLE;
        end else begin
          state_s = S_RELEASE;
        end
      end
      S_ENABLE: begin
        if (ready_s) begin
          if (idx_r == IDX_LAST) begin
            state_s = S_RUN;
          end else begin
            state_s = S_RELEASE;
            idx_s   = idx_r + 4'd1;
          end
        end else if (timer_r >= ACK_TO_LAST) begin
          state_s        = S_FAULT;
          error_code_s   = 2'd2;
          fault_domain_s = idx_r;
        end else begin
          state_s = S_ENABLE;
        end
      end
      S_RUN: begin
        // Losing lock outranks a coincident restart request.
        if (!pll_lock) begin
`ifdef RESET_SEQ_LOCK_LOSS_RESTART_EN
          state_s = S_LOCK_LOST;
          if (restart_count != 4'd15) begin
            restart_count_s = restart_count + 4'd1;
          end else begin
            restart_count_s = restart_count;
          end
`else
          state_s        = S_FAULT;
          error_code_s   = 2'd3;
          fault_domain_s = 4'd0;
`endif
        end else if (soft_restart) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_RUN;
        end
      end
`ifdef RESET_SEQ_LOCK_LOSS_RESTART_EN
      S_LOCK_LOST: begin
        state_s = S_PLL_ON;
      end
`endif
      S_FAULT: begin
        if (soft_restart) begin
          state_s        = S_IDLE;
          error_code_s   = 2'd0;
          fault_domain_s = 4'd0;
        end else begin
          state_s = S_FAULT;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Moore outputs derived from the state being entered, so they register on the same edge.
  always_comb begin
    pll_enable_s    = 1'b1;
    domain_reset_s  = domain_reset;
    domain_enable_s = domain_enable;
    case (state_s)
      S_IDLE, S_FAULT: begin
        pll_enable_s    = 1'b0;
        domain_reset_s  = DOM_ALL;
        domain_enable_s = DOM_NONE;
      end
`ifdef RESET_SEQ_LOCK_LOSS_RESTART_EN
      S_LOCK_LOST: begin
        domain_reset_s  = DOM_ALL;
        domain_enable_s = DOM_NONE;
      end
`endif
      S_PLL_ON, S_RUN: begin
        domain_reset_s  = domain_reset;
        domain_enable_s = domain_enable;
      end
      S_RELEASE: begin
        domain_reset_s = domain_reset & ~next_mask_s;
      end
      S_ENABLE: begin
        domain_enable_s = domain_enable | next_mask_s;
      end
      default: begin
        pll_enable_s    = 1'b0;
        domain_reset_s  = DOM_ALL;
        domain_enable_s = DOM_NONE;
      end
    endcase
  end

  // State, index and saturating timers; both timers clear whenever the state changes.
  always_ff @(posedge clk or negedge hard_reset) begin
    if (!hard_reset) begin
      state_r <= S_IDLE;
      idx_r   <= 4'd0;
      timer_r <= '0;
      stab_r  <= '0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      if (state_s != state_r) begin
        timer_r <= '0;
      end else if (timer_r != TIMER_MAX) begin
        timer_r <= timer_r + TW'(1);
      end else begin
        timer_r <= timer_r;
      end
      if ((state_s != state_r) || !pll_lock) begin
        stab_r <= '0;
      end else if (stab_r != STAB_MAX) begin
        stab_r <= stab_r + SW'(1);
      end else begin
        stab_r <= stab_r;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge hard_reset) begin
    if (!hard_reset) begin
      pll_enable    <= 1'b0;
      domain_reset  <= DOM_ALL;
      domain_enable <= DOM_NONE;
      seq_done      <= 1'b0;
      seq_error     <= 1'b0;
      error_code    <= 2'd0;
      fault_domain  <= 4'd0;
      restart_count <= 4'd0;
    end else begin
      pll_enable    <= pll_enable_s;
      domain_reset  <= domain_reset_s;
      domain_enable <= domain_enable_s;
      seq_done      <= (state_s == S_RUN);
      seq_error     <= (state_s == S_FAULT);
      error_code    <= error_code_s;
      fault_domain  <= fault_domain_s;
      restart_count <= restart_count_s;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed and random input traces against an
// event-time model of the sequence; honours RESET_SEQ_LOCK_LOSS_RESTART_EN when defined.
module tb_reset_sequencer;

  localparam int ND    = 3;
  localparam int DWELL = 4;
  localparam int LSTAB = 2;
  localparam int LTO   = 20;
  localparam int ATO   = 10;
  localparam int NC    = 160;
  localparam int PN    = NC + 48;

  typedef struct packed {
    logic          pll;
    logic [ND-1:0] rst;
    logic [ND-1:0] en;
    logic          done;
    logic          err;
    logic [1:0]    code;
    logic [3:0]    fd;
    logic [3:0]    rc;
  } out_t;

  localparam int PH_PLL   = 0;
  localparam int PH_DOM   = 1;
  localparam int PH_RUN   = 2;
  localparam int PH_FAULT = 3;
  localparam int PH_IDLE  = 4;

  logic          clk = 1'b0;
  logic          hard_reset;
  logic          pll_lock;
  logic [ND-1:0] domain_ready;
  logic          soft_restart;
  logic          pll_enable;
  logic [ND-1:0] domain_reset;
  logic [ND-1:0] domain_enable;
  logic          seq_done;
  logic          seq_error;
  logic [1:0]    error_code;
  logic [3:0]    fault_domain;
  logic [3:0]    restart_count;

  logic          lock_pat  [PN];
  logic [ND-1:0] ready_pat [PN];
  logic          soft_pat  [PN];
  out_t          exp_q     [NC+1];

  int n_cmp = 0;
  int n_bad = 0;
  int first_done;
  int first_err;

  reset_sequencer #(
    .NUM_DOMAINS (ND),
    .DWELL_CYCLES(DWELL),
    .LOCK_STABLE (LSTAB),
    .LOCK_TIMEOUT(LTO),
    .ACK_TIMEOUT (ATO)
  ) dut (
    .clk          (clk),
    .hard_reset   (hard_reset),
    .pll_lock     (pll_lock),
    .domain_ready (domain_ready),
    .soft_restart (soft_restart),
    .pll_enable   (pll_enable),
    .domain_reset (domain_reset),
    .domain_enable(domain_enable),
    .seq_done     (seq_done),
    .seq_error    (seq_error),
    .error_code   (error_code),
    .fault_domain (fault_domain),
    .restart_count(restart_count)
  );

  always #5 clk = ~clk;

  // Outputs from counts: the first 'released' domains are out of reset, the first 'enabled' are enabled.
  function automatic out_t mk(input bit pll, input int released, input int enabled, input bit done,
                              input bit err, input int code, input int fd, input int rc);
    out_t o;
    o.pll  = pll;
    o.rst  = ND'(~((1 << released) - 1));
    o.en   = ND'((1 << enabled) - 1);
    o.done = done;
    o.err  = err;
    o.code = 2'(code);
    o.fd   = 4'(fd);
    o.rc   = 4'(rc);
    return o;
  endfunction

  task automatic put(input int from, input int to, input out_t v);
    for (int n = from; n <= to; n++) begin
      if (n >= 0 && n <= NC) exp_q[n] = v;
    end
  endtask

  // Event-time model: each phase's length is found by scanning the input patterns.
  task automatic build_model(input int ncyc);
    int t, ph, dom, run, rel, en, hit, c, rc, code, fd;
    rc = 0; code = 0; fd = 0; dom = 0;
    exp_q[0] = mk(1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 0);
    t = 1; ph = PH_PLL;
    while (t <= ncyc) begin
      case (ph)
        PH_PLL: begin
          run = 0; rel = -1;
          for (int k = 0; k < LTO && rel < 0; k++) begin
            run = lock_pat[t+k] ? run + 1 : 0;
            if (run >= LSTAB) rel = t + k + 1;
          end
          if (rel < 0) begin
            put(t, t + LTO - 1, mk(1'b1, 0, 0, 1'b0, 1'b0, 0, 0, rc));
            t = t + LTO; code = 1; fd = 0; ph = PH_FAULT;
          end else begin
            put(t, rel - 1, mk(1'b1, 0, 0, 1'b0, 1'b0, 0, 0, rc));
            t = rel; dom = 0; ph = PH_DOM;
          end
        end
        PH_DOM: begin
          put(t, t + DWELL - 1, mk(1'b1, dom + 1, dom, 1'b0, 1'b0, 0, 0, rc));
          en = t + DWELL; hit = -1;
          for (int k = 0; k < ATO && hit < 0; k++) begin
            if (ready_pat[en+k][dom]) hit = en + k + 1;
          end
          if (hit < 0) begin
            put(en, en + ATO - 1, mk(1'b1, dom + 1, dom + 1, 1'b0, 1'b0, 0, 0, rc));
            t = en + ATO; code = 2; fd = dom; ph = PH_FAULT;
          end else begin
            put(en, hit - 1, mk(1'b1, dom + 1, dom + 1, 1'b0, 1'b0, 0, 0, rc));
            t = hit;
            if (dom == ND - 1) ph = PH_RUN;
            else dom = dom + 1;
          end
        end
        PH_RUN: begin
          c = t;
          while (c < NC && lock_pat[c] && !soft_pat[c]) c++;
          put(t, c, mk(1'b1, ND, ND, 1'b1, 1'b0, 0, 0, rc));
          t = c + 1;
          if (!lock_pat[c]) begin
`ifdef RESET_SEQ_LOCK_LOSS_RESTART_EN
            rc = (rc < 15) ? rc + 1 : 15;
            put(t, t, mk(1'b1, 0, 0, 1'b0, 1'b0, 0, 0, rc));
            t = t + 1; ph = PH_PLL;
`else
            code = 3; fd = 0; ph = PH_FAULT;
`endif
          end else begin
            ph = PH_IDLE;
          end
        end
        PH_FAULT: begin
          c = t;
          while (c < NC && !soft_pat[c]) c++;
          put(t, c, mk(1'b0, 0, 0, 1'b0, 1'b1, code, fd, rc));
          t = c + 1; code = 0; fd = 0; ph = PH_IDLE;
        end
        default: begin
          put(t, t, mk(1'b0, 0, 0, 1'b0, 1'b0, 0, 0, rc));
          t = t + 1; ph = PH_PLL;
        end
      endcase
    end
  endtask

  task automatic check(input string tag, input int n, input out_t want);
    out_t got;
    got = {pll_enable, domain_reset, domain_enable, seq_done, seq_error, error_code, fault_domain, restart_count};
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s edge %0d: observed pll=%b rst=%b en=%b done=%b err=%b code=%0d fd=%0d rc=%0d, expected pll=%b rst=%b en=%b done=%b err=%b code=%0d fd=%0d rc=%0d",
             tag, n, got.pll, got.rst, got.en, got.done, got.err, got.code, got.fd, got.rc,
             want.pll, want.rst, want.en, want.done, want.err, want.code, want.fd, want.rc);
    end
  endtask

  task automatic fill(input bit lock_v, input logic [ND-1:0] ready_v);
    for (int c = 0; c < PN; c++) begin
      lock_pat[c] = lock_v; ready_pat[c] = ready_v; soft_pat[c] = 1'b0;
    end
  endtask

  task automatic apply(input int c);
    pll_lock = lock_pat[c]; domain_ready = ready_pat[c]; soft_restart = soft_pat[c];
  endtask

  // Applies the patterns from a fresh hard reset and compares every edge; abort_at>0 pulls hard_reset mid-run.
  task automatic run_scenario(input string tag, input int ncyc, input int abort_at);
    build_model(ncyc);
    first_done = -1; first_err = -1;
    @(negedge clk);
    hard_reset = 1'b0; pll_lock = 1'b0; domain_ready = '0; soft_restart = 1'b0;
    @(negedge clk);
    check({tag, "_inreset"}, 0, exp_q[0]);
    hard_reset = 1'b1;
    apply(0);
    #1 check(tag, 0, exp_q[0]);
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk);
      #1;
      check(tag, n, exp_q[n]);
      if (seq_done && first_done < 0) first_done = n;
      if (seq_error && first_err < 0) first_err = n;
      if (n == abort_at) begin
        #2 hard_reset = 1'b0;
        #1 check({tag, "_async"}, n, mk(1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 0));
        break;
      end
      apply(n);
    end
  endtask

  initial begin
    int lowpct;
    int rise [ND];
    hard_reset = 1'b0; pll_lock = 1'b0; domain_ready = '0; soft_restart = 1'b0;

    fill(1'b1, {ND{1'b1}});
    run_scenario("nominal", 30, 0);
    n_cmp++;
    assert (first_done === 1 + LSTAB + ND * (DWELL + 1)) else begin
      n_bad++; $error("FAIL nominal_done_edge: observed %0d expected %0d", first_done, 1 + LSTAB + ND * (DWELL + 1));
    end

    fill(1'b1, {ND{1'b1}});
    lock_pat[1] = 1'b0;
    run_scenario("glitchy_lock", 30, 0);

    fill(1'b0, {ND{1'b1}});
    soft_pat[25] = 1'b1;
    for (int c = 30; c < PN; c++) lock_pat[c] = 1'b1;
    run_scenario("lock_timeout", 60, 0);
    n_cmp++;
    assert (first_err === 1 + LTO) else begin
      n_bad++; $error("FAIL lock_timeout_edge: observed %0d expected %0d", first_err, 1 + LTO);
    end

    fill(1'b1, 3'b101);
    run_scenario("ack_timeout", 40, 0);
    n_cmp++;
    assert (first_err === 1 + LSTAB + (DWELL + 1) + DWELL + ATO) else begin
      n_bad++; $error("FAIL ack_timeout_edge: observed %0d expected %0d", first_err, 1 + LSTAB + (DWELL + 1) + DWELL + ATO);
    end

    fill(1'b1, {ND{1'b1}});
    lock_pat[25] = 1'b0;
    soft_pat[35] = 1'b1;
    run_scenario("lock_loss", 70, 0);

    fill(1'b1, {ND{1'b1}});
    soft_pat[3] = 1'b1; soft_pat[8] = 1'b1; soft_pat[15] = 1'b1; soft_pat[22] = 1'b1;
    run_scenario("soft_ignored", 50, 0);

    fill(1'b1, {ND{1'b1}});
    run_scenario("mid_reset", 20, 9);

    for (int s = 0; s < 10; s++) begin
      case ($urandom_range(0, 3))
        0: lowpct = 0;
        1: lowpct = 3;
        2: lowpct = 15;
        default: lowpct = 60;
      endcase
      for (int d = 0; d < ND; d++) begin
        rise[d] = ($urandom_range(0, 7) == 0) ? PN : int'($urandom_range(0, 30));
      end
      for (int c = 0; c < PN; c++) begin
        lock_pat[c] = ($urandom_range(0, 99) >= lowpct);
        soft_pat[c] = ($urandom_range(0, 19) == 0);
        for (int d = 0; d < ND; d++) ready_pat[c][d] = (c >= rise[d]);
      end
      run_scenario("random", NC, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
